// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter and sequencer for a shared 256x8 RAM
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk2,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] eab,
    output logic [DW-1:0] din,
    output logic [1:0]    cword,
    input  logic [DW-1:0] edb,
    output logic          busy,
    output logic          owner
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    localparam logic [1:0] CW_IDLE  = 2'b00;
    localparam logic [1:0] CW_WRITE = 2'b01;
    localparam logic [1:0] CW_READ  = 2'b10;

    state_t        r_state;
    logic [AW-1:0] r_eab;
    logic [DW-1:0] r_din;
    logic [1:0]    r_cword;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_busy;
    logic          r_owner;
    logic          r_lock;

    logic [1:0]    w_req;
    logic          w_gnt_vld;
    logic          w_gnt_id;
    logic          w_sel_we;
    logic          w_sel_lock;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // On a tie the lock flag keeps the current owner, otherwise the other side wins.
    always_comb begin
        w_req     = {req1, req0};
        w_gnt_vld = |w_req;
        if (w_req == 2'b11) begin
            w_gnt_id = r_lock ? r_owner : ~r_owner;
        end else begin
            w_gnt_id = w_req[1];
        end
        w_sel_we    = w_gnt_id ? we1    : we0;
        w_sel_lock  = w_gnt_id ? lock1  : lock0;
        w_sel_addr  = w_gnt_id ? addr1  : addr0;
        w_sel_wdata = w_gnt_id ? wdata1 : wdata0;
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_eab    <= '0;
            r_din    <= '0;
            r_cword  <= CW_IDLE;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_busy   <= 1'b0;
            r_owner  <= 1'b1;
            r_lock   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    if (w_gnt_vld) begin
                        r_eab   <= w_sel_addr;
                        r_din   <= w_sel_we ? w_sel_wdata : '0;
                        r_cword <= w_sel_we ? CW_WRITE : CW_READ;
                        r_owner <= w_gnt_id;
                        r_busy  <= 1'b1;
                        r_lock  <= w_sel_lock;
                        r_state <= ST_BUS;
                    end else begin
                        // Nobody requesting means a locked owner has let go.
                        r_cword <= CW_IDLE;
                        r_lock  <= 1'b0;
                    end
                end
                ST_BUS: begin
                    if (r_owner) begin
                        r_ack1 <= 1'b1;
                        if (r_cword == CW_READ) r_rdata1 <= edb;
                    end else begin
                        r_ack0 <= 1'b1;
                        if (r_cword == CW_READ) r_rdata0 <= edb;
                    end
                    r_cword <= CW_IDLE;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign eab    = r_eab;
    assign din    = r_din;
    assign cword  = r_cword;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign busy   = r_busy;
    assign owner  = r_owner;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a shadow-memory reference model
module tb_ram_arbiter;

    logic       clk2 = 1'b0;
    logic       reset;
    logic       req0, we0, lock0, req1, we1, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, busy, owner;
    logic [7:0] rdata0, rdata1, eab, din, edb;
    logic [1:0] cword;
    logic [7:0] mem [256];
    int         checks = 0;
    int         errors = 0;

    always #5 clk2 = ~clk2;

    ram_arbiter #(.AW(8), .DW(8)) dut (
        .clk2(clk2), .reset(reset),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .eab(eab), .din(din), .cword(cword), .edb(edb), .busy(busy), .owner(owner)
    );

    // RAM: combinational read, write lands at the posedge ending a write cycle
    assign edb = mem[eab];
    always @(posedge clk2) if (cword == 2'b01) mem[eab] <= din;

    task automatic idle_inputs();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk2);
        checks++; if (eab !== 8'h00) begin errors++; $display("FAIL reset_eab: got %0h expected 0", eab); end
        checks++; if (din !== 8'h00) begin errors++; $display("FAIL reset_din: got %0h expected 0", din); end
        checks++; if (cword !== 2'b00) begin errors++; $display("FAIL reset_cword: got %0b expected 00", cword); end
        checks++; if ({rdata1, rdata0} !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", {rdata1, rdata0}); end
        checks++; if ({ack1, ack0, busy} !== 3'b000) begin errors++; $display("FAIL reset_ack_busy: got %0b expected 000", {ack1, ack0, busy}); end
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner: got %0b expected 1", owner); end
        reset = 1'b1;
        @(negedge clk2);
        checks++; if (busy !== 1'b0 || cword !== 2'b00) begin errors++; $display("FAIL reset_idle: busy %0b cword %0b expected 0/00", busy, cword); end
    endtask

    task automatic test_single_read();
        req0 = 1; we0 = 0; addr0 = 8'd9;
        @(negedge clk2);
        checks++; if (eab !== 8'd9 || cword !== 2'b10) begin errors++; $display("FAIL read_bus: eab %0h cword %0b expected 09/10", eab, cword); end
        checks++; if (busy !== 1'b1 || owner !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL read_busy: busy %0b owner %0b ack0 %0b expected 1/0/0", busy, owner, ack0); end
        @(negedge clk2);
        checks++; if (ack0 !== 1'b1 || rdata0 !== 8'd2) begin errors++; $display("FAIL read_ack: ack0 %0b rdata0 %0h expected 1/02", ack0, rdata0); end
        checks++; if (cword !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL read_ackcyc: cword %0b busy %0b expected 00/0", cword, busy); end
        req0 = 0;
        @(negedge clk2);
        checks++; if (ack0 !== 1'b0 || cword !== 2'b00) begin errors++; $display("FAIL read_after: ack0 %0b cword %0b expected 0/00", ack0, cword); end
    endtask

    task automatic test_single_write();
        req1 = 1; we1 = 1; addr1 = 8'd20; wdata1 = 8'hAA;
        @(negedge clk2);
        checks++; if (cword !== 2'b01 || eab !== 8'd20 || din !== 8'hAA) begin errors++; $display("FAIL write_bus: cword %0b eab %0h din %0h expected 01/14/aa", cword, eab, din); end
        checks++; if (owner !== 1'b1 || ack1 !== 1'b0) begin errors++; $display("FAIL write_owner: owner %0b ack1 %0b expected 1/0", owner, ack1); end
        @(negedge clk2);
        checks++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin errors++; $display("FAIL write_ack: ack1 %0b ack0 %0b expected 1/0", ack1, ack0); end
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 8'd20;
        repeat (2) @(negedge clk2);
        checks++; if (ack0 !== 1'b1 || rdata0 !== 8'hAA) begin errors++; $display("FAIL write_readback: ack0 %0b rdata0 %0h expected 1/aa", ack0, rdata0); end
        req0 = 0;
        @(negedge clk2);
    endtask

    task automatic test_contention();
        int acks_seen = 0;
        int last_id = 0;     // previous owner was requester 0, so 1 wins the first tie
        int last_cyc [2] = '{-10, -10};
        req0 = 1; we0 = 0; addr0 = 8'd1;
        req1 = 1; we1 = 0; addr1 = 8'd2;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk2);
            checks++; if (ack0 && ack1) begin errors++; $display("FAIL cont_both_ack: cycle %0d both acks high, required one at most", c); end
            if (ack0 || ack1) begin
                int id = ack1 ? 1 : 0;
                acks_seen++;
                checks++; if (id == last_id) begin errors++; $display("FAIL cont_alternate: ack %0d went to %0d, required %0d", acks_seen, id, 1 - last_id); end
                checks++; if (last_cyc[id] >= 0 && c - last_cyc[id] != 4) begin errors++; $display("FAIL cont_spacing: requester %0d gap %0d, required 4", id, c - last_cyc[id]); end
                last_id = id;
                last_cyc[id] = c;
            end
            if (c == 16) begin req0 = 0; req1 = 0; end
        end
        checks++; if (acks_seen != 8) begin errors++; $display("FAIL cont_count: got %0d acks expected 8", acks_seen); end
        @(negedge clk2);
    endtask

    task automatic test_lock();
        req0 = 1; we0 = 0; addr0 = 8'd5; lock0 = 1;
        @(negedge clk2);
        req1 = 1; we1 = 0; addr1 = 8'd7; lock1 = 0;
        @(negedge clk2);
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL lock_first_ack: ack0 %0b expected 1", ack0); end
        we0 = 1; wdata0 = 8'h3C; lock0 = 0;
        @(negedge clk2);
        checks++; if (owner !== 1'b0 || cword !== 2'b01 || eab !== 8'd5) begin errors++; $display("FAIL lock_hold: owner %0b cword %0b eab %0h expected 0/01/05", owner, cword, eab); end
        @(negedge clk2);
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL lock_second_ack: ack0 %0b expected 1", ack0); end
        req0 = 0; we0 = 0;
        @(negedge clk2);
        checks++; if (owner !== 1'b1 || cword !== 2'b10 || eab !== 8'd7) begin errors++; $display("FAIL lock_release: owner %0b cword %0b eab %0h expected 1/10/07", owner, cword, eab); end
        @(negedge clk2);
        checks++; if (ack1 !== 1'b1 || rdata1 !== (8'd7 ^ 8'h5A)) begin errors++; $display("FAIL lock_r1_data: ack1 %0b rdata1 %0h expected 1/%0h", ack1, rdata1, 8'd7 ^ 8'h5A); end
        req1 = 0;
        checks++; if (mem[5] !== 8'h3C) begin errors++; $display("FAIL lock_write_mem: got %0h expected 3c", mem[5]); end
        @(negedge clk2);
    endtask

    task automatic test_reset_mid();
        req0 = 1; we0 = 1; addr0 = 8'd30; wdata0 = 8'h55;
        @(negedge clk2);
        checks++; if (busy !== 1'b1 || cword !== 2'b01) begin errors++; $display("FAIL rmid_bus: busy %0b cword %0b expected 1/01", busy, cword); end
        reset = 1'b0;
        #1;
        checks++; if (cword !== 2'b00 || busy !== 1'b0 || eab !== 8'h00 || din !== 8'h00) begin errors++; $display("FAIL rmid_clear: cword %0b busy %0b eab %0h din %0h expected 00/0/0/0", cword, busy, eab, din); end
        checks++; if (owner !== 1'b1 || {ack1, ack0} !== 2'b00 || {rdata1, rdata0} !== 16'h0) begin errors++; $display("FAIL rmid_outs: owner %0b acks %0b rdata %0h expected 1/00/0", owner, {ack1, ack0}, {rdata1, rdata0}); end
        idle_inputs();
        @(negedge clk2);
        checks++; if (mem[30] !== 8'h11) begin errors++; $display("FAIL rmid_mem: got %0h expected 11", mem[30]); end
        checks++; if ({ack1, ack0} !== 2'b00) begin errors++; $display("FAIL rmid_noack: acks %0b expected 00", {ack1, ack0}); end
        reset = 1'b1;
        @(negedge clk2);
        checks++; if ({ack1, ack0, busy} !== 3'b000) begin errors++; $display("FAIL rmid_after: ack/busy %0b expected 000", {ack1, ack0, busy}); end
    endtask

    task automatic test_back_to_back();
        req0 = 1; we0 = 0; addr0 = 8'd0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk2);
            checks++; if (busy !== c[0]) begin errors++; $display("FAIL b2b_busy: cycle %0d busy %0b expected %0b", c, busy, c[0]); end
            if (!c[0]) begin
                checks++; if (ack0 !== 1'b1 || rdata0 !== (8'(c / 2 - 1) ^ 8'h5A)) begin errors++; $display("FAIL b2b_data: cycle %0d ack0 %0b rdata0 %0h expected 1/%0h", c, ack0, rdata0, 8'(c / 2 - 1) ^ 8'h5A); end
                addr0 = 8'(c / 2);
                if (c == 6) req0 = 0;
            end
        end
        @(negedge clk2);
    endtask

    task automatic test_random();
        logic [7:0] model [256];
        int         target = 60;
        int         done_n [2] = '{0, 0};
        int         gap [2] = '{0, 1};
        int         wait_c [2];
        logic       act [2] = '{1'b0, 1'b0};
        logic       seen [2];
        logic       lr_v [2] = '{1'b0, 1'b0};
        logic       t_we [2];
        logic [7:0] t_addr [2], t_wd [2], last_rd [2];
        int         cyc = 0;
        for (int i = 0; i < 256; i++) begin
            model[i] = 8'($urandom);
            mem[i] = model[i];
        end
        while ((done_n[0] < target || done_n[1] < target) && cyc < 4000) begin
            @(negedge clk2);
            cyc++;
            checks++; if (ack0 && ack1) begin errors++; $display("FAIL rnd_both_ack: cycle %0d both acks high", cyc); end
            for (int n = 0; n < 2; n++) begin
                logic       a;
                logic [7:0] rd;
                a  = (n == 1) ? ack1 : ack0;
                rd = (n == 1) ? rdata1 : rdata0;
                if (act[n]) begin
                    if (busy && owner == 1'(n) && !seen[n]) begin
                        seen[n] = 1'b1;
                        checks++; if (eab !== t_addr[n] || cword !== (t_we[n] ? 2'b01 : 2'b10) || din !== (t_we[n] ? t_wd[n] : 8'h00)) begin
                            errors++; $display("FAIL rnd_bus: req %0d eab %0h cword %0b din %0h expected %0h/%0b/%0h", n, eab, cword, din, t_addr[n], t_we[n] ? 2'b01 : 2'b10, t_we[n] ? t_wd[n] : 8'h00);
                        end
                    end
                    if (a) begin
                        checks++; if (!seen[n]) begin errors++; $display("FAIL rnd_ack_early: req %0d ack without bus cycle"
                            , n); end
                        if (t_we[n]) begin
                            model[t_addr[n]] = t_wd[n];
                            if (lr_v[n]) begin
                                checks++; if (rd !== last_rd[n]) begin errors++; $display("FAIL rnd_wr_keep: req %0d rdata %0h expected %0h", n, rd, last_rd[n]); end
                            end
                        end else begin
                            checks++; if (rd !== model[t_addr[n]]) begin errors++; $display("FAIL rnd_rd_data: req %0d addr %0h rdata %0h expected %0h", n, t_addr[n], rd, model[t_addr[n]]); end
                            last_rd[n] = model[t_addr[n]];
                            lr_v[n] = 1'b1;
                        end
                        act[n] = 1'b0;
                        done_n[n]++;
                        gap[n] = $urandom_range(0, 2);
                    end else if (++wait_c[n] > 40) begin
                        checks++; errors++;
                        $display("FAIL rnd_timeout: req %0d waited %0d cycles, required ack", n, wait_c[n]);
                        act[n] = 1'b0;
                        done_n[n]++;
                    end
                end
                if (!act[n]) begin
                    if (gap[n] > 0 || done_n[n] >= target) begin
                        if (gap[n] > 0) gap[n]--;
                        if (n == 0) req0 = 0; else req1 = 0;
                    end else begin
                        act[n] = 1'b1; seen[n] = 1'b0; wait_c[n] = 0;
                        t_we[n] = 1'($urandom);
                        case ($urandom_range(0, 7))
                            0: t_addr[n] = 8'hFF;
                            1: t_addr[n] = 8'h00;
                            default: t_addr[n] = 8'($urandom);
                        endcase
                        t_wd[n] = 8'($urandom);
                        if (n == 0) begin
                            req0 = 1; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wd[0]; lock0 = ($urandom_range(0, 3) == 0);
                        end else begin
                            req1 = 1; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wd[1]; lock1 = ($urandom_range(0, 3) == 0);
                        end
                    end
                end
            end
        end
        checks++; if (done_n[0] != target || done_n[1] != target) begin errors++; $display("FAIL rnd_done: completed %0d/%0d expected %0d each", done_n[0], done_n[1], target); end
        idle_inputs();
        repeat (3) @(negedge clk2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[9]  = 8'd2;
        mem[30] = 8'h11;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_lock();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 256x8 RAM.
- Requester 0 is the CPU fetch/execute unit; requester 1 is the loader/DMA unit.
- Drives the RAM address (eab), write data (din) and control word (cword), and returns read data captured from edb.
- Round-robin arbitration; a per-requester lock holds ownership for read-modify-write sequences.

Parameters:
- AW, 8, address width (eab and addrN).
- DW, 8, data width (edb, din, wdataN, rdataN).

Ports:
- clk2  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 transfer request, level.
- we0  input  1  requester 0 write (1) / read (0), valid with req0.
- lock0  input  1  requester 0 keeps priority at the next arbitration.
- addr0  input  AW  requester 0 address.
- wdata0  input  DW  requester 0 write data.
- ack0  output  1  one-cycle completion pulse to requester 0.
- rdata0  output  DW  requester 0 read data, valid while ack0=1.
- req1, we1, lock1, addr1, wdata1, ack1, rdata1: same as the requester 0 set, for requester 1.
- eab  output  AW  RAM address.
- din  output  DW  RAM write data.
- cword  output  2  RAM control: 00 idle, 01 write, 10 read.
- edb  input  DW  RAM read data, combinational from eab.
- busy  output  1  high while a transfer occupies the RAM (state BUS).
- owner  output  1  ID of the current or most recent grantee.

Behaviour:
- Reset values (asynchronous, reset=0):
  - State=IDLE.
  - eab, din, rdata0 and rdata1 = 0.
  - cword=00.
  - ack0, ack1 and busy = 0.
  - owner=1, so requester 0 wins the first tie.
  - Lock-priority flag cleared.
- All outputs are registered.
- FSM has two states:
  - IDLE, at each posedge:
    - No req: stay in IDLE; cword=00.
    - Exactly one req: grant that requester.
    - Both req: if the lock-priority flag is set, grant the flagged requester. Otherwise grant the requester that is not equal to owner.
    - On grant, register eab=addrN and din=wdataN (din=0 on reads) and cword=01 if weN else 10. Set owner=N, busy=1, lock flag=lockN, and go to BUS.
  - BUS, lasts exactly one cycle:
    - The RAM sees a stable address and control for the whole cycle.
    - A write lands at the posedge that ends BUS.
    - At that posedge: rdataN<=edb (reads only; on writes rdataN keeps its old value), ackN<=1, cword<=00, busy<=0, and go to IDLE.
- Latency: the request is sampled at posedge k, the RAM access happens during cycle k..k+1, and ackN is high in cycle k+1..k+2.
- Throughput: at most one transfer per 2 cycles.
- Handshake:
  - The requester holds reqN, weN, addrN and wdataN stable until ackN.
  - During the ack cycle the FSM is in IDLE. If reqN is still high at the posedge ending that cycle, it is taken as a new request.
  - A requester wanting a single transfer deasserts reqN in the ack cycle.
- Lock:
  - lockN=1 at grant makes N win the next arbitration even if the other requester is waiting.
  - The flag clears at any grant made with lockN=0.
  - If the locked owner drops req, the flag clears and normal round-robin resumes.
- Request changes during BUS are ignored; addresses and data are captured only at grant.
- Only one of ack0/ack1 is ever high, and never both.
- Reset asserted during BUS:
  - Transfer aborted; cword forced to 00 immediately, so no write occurs.
  - No ack is issued.
- Address wraps naturally at 255; no range checking.
- After reset deassertion the first grant is at the first posedge with a request pending.

Test Plan:
- Reset then single read: req0=1, we0=0, addr0=9 with RAM[9]=2. eab=9 and cword=10 one cycle after the sampling posedge; ack0=1 and rdata0=2 in the next cycle; cword=00 after that.
- Single write: req1=1, we1=1, addr1=20, wdata1=0xAA. cword=01, eab=20, din=0xAA for one cycle, then ack1. A following read of 20 by requester 0 returns 0xAA.
- Contention: req0 and req1 held high continuously. Grants alternate 0,1,0,1; each requester gets an ack every 4 cycles; ack0 and ack1 are never both high.
- Lock: requester 0 does read addr 5 with lock0=1, then write addr 5, while req1 is held high. The requester 0 write is granted before requester 1. Requester 1 is granted next after lock0=0.
- Reset mid-transfer: drive reset low during BUS of a write to addr 30 with data 0x55. cword=00 immediately, no ack, RAM[30] unchanged, all outputs at reset values.
- Idle/back-to-back: req0 held with addr stepping 0,1,2 on each ack0. Acks arrive every 2 cycles with rdata matching RAM[0..2]; busy toggles 1,0 each cycle.
